// File: rtl/bram_pattern_check.sv
// Reads a BRAM region word by word and checks it against the ramp k*DATA_STEP.
// Optional first-mismatch capture is built when BRAM_CHECK_FIRST_ERR_EN is defined.
module bram_pattern_check #(
  parameter int unsigned DATA_STEP = 2,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [31:0] len,
  input  logic [31:0] start_addr,
  input  logic [31:0] ram_din,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic        ram_rst,
  output logic [31:0] ram_addr,
  output logic        busy,
  output logic        check_done,
  output logic        check_pass,
  output logic [15:0] err_cnt,
  output logic [31:0] first_err_addr,
  output logic [31:0] first_err_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t            state;
  logic [31:0]       words_left;
  logic [31:0]       exp_val;
  logic [31:0]       n_words;
  logic [RD_LAT-1:0] pipe_vld;
  logic [31:0]       pipe_exp [RD_LAT];
  logic              mismatch;

  assign ram_we   = '0;
  assign ram_rst  = 1'b0;
  assign n_words  = len >> 2;
  assign mismatch = pipe_vld[RD_LAT-1] && (ram_din != pipe_exp[RD_LAT-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      busy       <= 1'b0;
      check_done <= 1'b0;
      check_pass <= 1'b0;
      err_cnt    <= '0;
      words_left <= '0;
      exp_val    <= '0;
      pipe_vld   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_exp[i] <= '0;
    end else begin
      check_done  <= 1'b0;
      pipe_vld[0] <= ram_en;
      pipe_exp[0] <= exp_val;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end
      if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (trig) begin
            err_cnt    <= '0;
            check_pass <= 1'b0;
            busy       <= 1'b1;
            exp_val    <= '0;
            // An empty region passes through DRAIN (pipeline already empty),
            // giving the same one-cycle spacing before FINISH as a real check.
            if (n_words == '0) begin
              state <= DRAIN;
            end else begin
              state      <= ISSUE;
              ram_en     <= 1'b1;
              ram_addr   <= start_addr;
              words_left <= n_words - 32'd1;
            end
          end
        end
        ISSUE: begin
          if (words_left == '0) begin
            ram_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            ram_addr   <= ram_addr + 32'd4;
            exp_val    <= exp_val + DATA_STEP;
            words_left <= words_left - 32'd1;
          end
        end
        DRAIN: begin
          if (pipe_vld == '0) state <= FINISH;
        end
        FINISH: begin
          check_done <= 1'b1;
          check_pass <= (err_cnt == '0);
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRAM_CHECK_FIRST_ERR_EN
  logic [31:0] pipe_addr [RD_LAT];
  logic        first_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_seen     <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_addr[0] <= ram_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
      if ((state == IDLE) && trig) begin
        first_seen     <= 1'b0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else if (mismatch && !first_seen) begin
        first_seen     <= 1'b1;
        first_err_addr <= pipe_addr[RD_LAT-1];
        first_err_data <= ram_din;
      end
    end
  end
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_bram_pattern_check.sv
// Scoreboard bench for bram_pattern_check: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_bram_pattern_check;

`ifdef BRAM_CHECK_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  typedef struct {
    int          id;
    int          lat;
    logic        pass;
    logic [15:0] err;
    logic [31:0] fea;
    logic [31:0] fed;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        trig1, trig3;
  logic [31:0] len1, sa1, din1, len3, sa3, din3;
  logic        en1, en3, rr1, rr3, busy1, busy3, done1, done3, pass1, pass3;
  logic [3:0]  we1, we3;
  logic [31:0] addr1, addr3, fea1, fed1, fea3, fed3;
  logic [15:0] err1, err3;

  bram_pattern_check #(.DATA_STEP(2), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .trig(trig1), .len(len1), .start_addr(sa1), .ram_din(din1),
    .ram_en(en1), .ram_we(we1), .ram_rst(rr1), .ram_addr(addr1), .busy(busy1),
    .check_done(done1), .check_pass(pass1), .err_cnt(err1),
    .first_err_addr(fea1), .first_err_data(fed1));

  bram_pattern_check #(.DATA_STEP(2), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .trig(trig3), .len(len3), .start_addr(sa3), .ram_din(din3),
    .ram_en(en3), .ram_we(we3), .ram_rst(rr3), .ram_addr(addr3), .busy(busy3),
    .check_done(done3), .check_pass(pass3), .err_cnt(err3),
    .first_err_addr(fea3), .first_err_data(fed3));

  // BRAM models: capture on the edge after the address, RD_LAT-1 extra register stages
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] r1;
  logic [31:0] r3 [3];
  always @(posedge clk) begin
    r1    <= mem1[addr1[9:2]];
    r3[0] <= mem3[addr3[9:2]];
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign din1 = r1;
  assign din3 = r3[2];

  int tests = 0;
  int fails = 0;
  exp_t sb [$];
  logic [31:0] aq1 [$];
  bit   chk_addr1 = 1'b0;
  int   tc1 = 0, tc3 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int id, input int lat, input logic p, input int e,
                              input logic [31:0] fa, input logic [31:0] fd);
    exp_t x;
    x.id = id; x.lat = lat; x.pass = p; x.err = 16'(e);
    x.fea = FE ? fa : 32'h0;
    x.fed = FE ? fd : 32'h0;
    return x;
  endfunction

  task automatic on_done(input int id, input int tc, input logic p, input logic [15:0] e,
                         input logic [31:0] fa, input logic [31:0] fd);
    exp_t x;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_done: dut%0d got check_done expected none", id);
    end else begin
      x = sb.pop_front();
      chk("done_source", id, x.id);
      chk("latency", cyc - tc - 1, x.lat);
      chk("check_pass", {31'b0, p}, {31'b0, x.pass});
      chk("err_cnt", {16'b0, e}, {16'b0, x.err});
      chk("first_err_addr", fa, x.fea);
      chk("first_err_data", fd, x.fed);
    end
  endtask

  // Monitor: decoupled from stimulus, pops the scoreboard on every completion
  always @(negedge clk) begin
    if (done1) on_done(1, tc1, pass1, err1, fea1, fed1);
    if (done3) on_done(3, tc3, pass3, err3, fea3, fed3);
    if (en1 && chk_addr1) begin
      if (aq1.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ram_en: got addr 0x%0h expected no read", addr1);
      end else begin
        chk("ram_addr", addr1, aq1.pop_front());
      end
    end
  end

  task automatic start1(input logic [31:0] l, input logic [31:0] sa, input bit push,
                        input exp_t x, input bit rel_rst);
    @(negedge clk);
    len1 = l; sa1 = sa; trig1 = 1'b1; tc1 = cyc;
    if (rel_rst) rst = 1'b0;
    if (push) begin
      sb.push_back(x);
      for (int k = 0; k < int'(l >> 2); k++) aq1.push_back(sa + 32'(4 * k));
    end
    @(negedge clk);
    trig1 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk); #1; n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no check_done expected %0d more", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
    chk("addr_queue_drained", aq1.size(), 0);
    aq1.delete();
  endtask

  task automatic reset_outputs_check();
    chk("rst_ram_en", {31'b0, en1}, 32'h0);
    chk("rst_ram_addr", addr1, 32'h0);
    chk("rst_busy", {31'b0, busy1}, 32'h0);
    chk("rst_check_done", {31'b0, done1}, 32'h0);
    chk("rst_check_pass", {31'b0, pass1}, 32'h0);
    chk("rst_err_cnt", {16'b0, err1}, 32'h0);
    chk("rst_first_err_addr", fea1, 32'h0);
    chk("rst_first_err_data", fed1, 32'h0);
  endtask

  initial begin
    exp_t none;
    none = mk(0, 0, 1'b0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'hFFFF_0000 | 32'(i);
      mem3[i] = 32'hFFFF_0000 | 32'(i);
    end
    for (int k = 0; k < 16; k++) mem1[16 + k] = 32'(2 * k);
    for (int k = 0; k < 8; k++)  mem3[k] = 32'(2 * k);
    mem1[254] = 32'd0; mem1[255] = 32'd2; mem1[0] = 32'd4; mem1[1] = 32'd6;
    trig1 = 1'b0; trig3 = 1'b0; len1 = '0; sa1 = '0; len3 = '0; sa3 = '0;

    // Reset state
    rst = 1'b1;
    #1;
    reset_outputs_check();
    chk("ram_we_const", {28'b0, we1}, 32'h0);
    chk("ram_rst_const", {31'b0, rr1}, 32'h0);
    chk("rst_busy3", {31'b0, busy3}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clean pattern, RD_LAT=1
    chk_addr1 = 1'b1;
    start1(32'd16, 32'h40, 1'b1, mk(1, 7, 1'b1, 0, 32'h0, 32'h0), 1'b0);
    #1 chk("busy_during_check", {31'b0, busy1}, 32'h1);
    wait_idle();

    // Single corrupted word
    mem1[18] = 32'hDEAD;
    start1(32'd16, 32'h40, 1'b1, mk(1, 7, 1'b0, 1, 32'h48, 32'hDEAD), 1'b0);
    wait_idle();

    // Second mismatch must not replace the first-error capture
    mem1[19] = 32'h1234;
    start1(32'd16, 32'h40, 1'b1, mk(1, 7, 1'b0, 2, 32'h48, 32'hDEAD), 1'b0);
    wait_idle();
    mem1[18] = 32'd4; mem1[19] = 32'd6;

    // Empty regions: len=0 and len=3, no reads
    start1(32'd0, 32'h40, 1'b1, mk(1, 2, 1'b1, 0, 32'h0, 32'h0), 1'b0);
    wait_idle();
    start1(32'd3, 32'h40, 1'b1, mk(1, 2, 1'b1, 0, 32'h0, 32'h0), 1'b0);
    wait_idle();

    // Address wrap across 2^32, len not a multiple of 4
    start1(32'd19, 32'hFFFF_FFF8, 1'b1, mk(1, 7, 1'b1, 0, 32'h0, 32'h0), 1'b0);
    wait_idle();

    // RD_LAT=3, second trig while busy is ignored
    mem3[64] = 32'h0BAD;
    @(negedge clk);
    len3 = 32'd32; sa3 = 32'h0; trig3 = 1'b1; tc3 = cyc;
    sb.push_back(mk(3, 13, 1'b1, 0, 32'h0, 32'h0));
    @(negedge clk);
    trig3 = 1'b0;
    repeat (3) @(negedge clk);
    len3 = 32'd4; sa3 = 32'h100; trig3 = 1'b1;
    @(negedge clk);
    trig3 = 1'b0;
    wait_idle();

    // Reset during ISSUE aborts without completion
    chk_addr1 = 1'b0;
    start1(32'd16, 32'h40, 1'b0, none, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_outputs_check();
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", sb.size(), 0);

    // Trig accepted on the first edge after release
    chk_addr1 = 1'b1;
    start1(32'd16, 32'h40, 1'b1, mk(1, 7, 1'b1, 0, 32'h0, 32'h0), 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
